// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard scheduler: decoder hazard optypes and
// ID-stage forwarding source selects.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      OPT_NONE  = 2'b00,
      OPT_ALU   = 2'b01,
      OPT_LOAD  = 2'b10,
      OPT_STORE = 2'b11
   } opt_e;

   typedef enum logic [1:0] {
      FWD_RF       = 2'b00,
      FWD_EX_ALU   = 2'b01,
      FWD_MEM_ALU  = 2'b10,
      FWD_MEM_LOAD = 2'b11
   } fwd_e;

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against one pipeline stage's producer;
// only ALU writers and loads can match, and x0 never does.
module hazard_match
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  logic              use_i,
   input  logic [REG_AW-1:0] addr_i,
   input  logic [REG_AW-1:0] stage_rd_i,
   input  opt_e              stage_opt_i,
   output logic              alu_hit_o,
   output logic              load_hit_o
);

   logic addr_hit;

   always_comb begin
      addr_hit   = use_i && (addr_i != '0) && (addr_i == stage_rd_i);
      alu_hit_o  = addr_hit && (stage_opt_i == OPT_ALU);
      load_hit_o = addr_hit && (stage_opt_i == OPT_LOAD);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: shadows EX/MEM producers and drives operand
// forwarding, store-data forwarding, load-use stalls and branch flushes.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned OPT_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_addr_ID,
   input  logic [REG_AW-1:0] rs2_addr_ID,
   input  logic [REG_AW-1:0] rd_ID,
   input  logic              rs1use_ID,
   input  logic              rs2use_ID,
   input  logic [OPT_W-1:0]  hazard_optype_ID,
   input  logic              branch_taken_ID,
   output logic [1:0]        forward_ctrl_A,
   output logic [1:0]        forward_ctrl_B,
   output logic              forward_ctrl_ls,
   output logic              PC_EN_IF,
   output logic              reg_FD_EN,
   output logic              reg_FD_flush,
   output logic              reg_DE_flush
);

   opt_e              ex_opt_q,  ex_opt_d,  mem_opt_q;
   logic [REG_AW-1:0] ex_rd_q,   ex_rd_d,   mem_rd_q;
   logic              ex_ls_q,   ex_ls_d,   mem_ls_q;

   opt_e id_opt;
   logic ex_alu_a, ex_ld_a, mem_alu_a, mem_ld_a;
   logic ex_alu_b, ex_ld_b, mem_alu_b, mem_ld_b;
   logic stall, ls_req;
   fwd_e fwd_a, fwd_b;

   assign id_opt = opt_e'(hazard_optype_ID);

   hazard_match #(.REG_AW(REG_AW)) u_match_a_ex (
      .use_i(rs1use_ID), .addr_i(rs1_addr_ID), .stage_rd_i(ex_rd_q),
      .stage_opt_i(ex_opt_q), .alu_hit_o(ex_alu_a), .load_hit_o(ex_ld_a)
   );
   hazard_match #(.REG_AW(REG_AW)) u_match_a_mem (
      .use_i(rs1use_ID), .addr_i(rs1_addr_ID), .stage_rd_i(mem_rd_q),
      .stage_opt_i(mem_opt_q), .alu_hit_o(mem_alu_a), .load_hit_o(mem_ld_a)
   );
   hazard_match #(.REG_AW(REG_AW)) u_match_b_ex (
      .use_i(rs2use_ID), .addr_i(rs2_addr_ID), .stage_rd_i(ex_rd_q),
      .stage_opt_i(ex_opt_q), .alu_hit_o(ex_alu_b), .load_hit_o(ex_ld_b)
   );
   hazard_match #(.REG_AW(REG_AW)) u_match_b_mem (
      .use_i(rs2use_ID), .addr_i(rs2_addr_ID), .stage_rd_i(mem_rd_q),
      .stage_opt_i(mem_opt_q), .alu_hit_o(mem_alu_b), .load_hit_o(mem_ld_b)
   );

   always_comb begin
      fwd_a = FWD_RF;
      if (ex_alu_a)       fwd_a = FWD_EX_ALU;
      else if (mem_alu_a) fwd_a = FWD_MEM_ALU;
      else if (mem_ld_a)  fwd_a = FWD_MEM_LOAD;

      fwd_b = FWD_RF;
      if (ex_alu_b)       fwd_b = FWD_EX_ALU;
      else if (mem_alu_b) fwd_b = FWD_MEM_ALU;
      else if (mem_ld_b)  fwd_b = FWD_MEM_LOAD;

      // A store whose data comes from the EX load skips the stall; the loaded
      // value is picked up two stages later when the store sits in MEM.
      ls_req = (id_opt == OPT_STORE) && ex_ld_b && !ex_ld_a;
      if (ls_req) fwd_b = FWD_RF;

      stall = !rst && (ex_ld_a || (ex_ld_b && (id_opt != OPT_STORE)));

      if (stall) begin
         ex_opt_d = OPT_NONE;
         ex_rd_d  = '0;
         ex_ls_d  = 1'b0;
      end else begin
         ex_opt_d = id_opt;
         ex_rd_d  = rd_ID;
         ex_ls_d  = ls_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_opt_q  <= OPT_NONE;
         ex_rd_q   <= '0;
         ex_ls_q   <= 1'b0;
         mem_opt_q <= OPT_NONE;
         mem_rd_q  <= '0;
         mem_ls_q  <= 1'b0;
      end else begin
         mem_opt_q <= ex_opt_q;
         mem_rd_q  <= ex_rd_q;
         mem_ls_q  <= ex_ls_q;
         ex_opt_q  <= ex_opt_d;
         ex_rd_q   <= ex_rd_d;
         ex_ls_q   <= ex_ls_d;
      end
   end

   assign forward_ctrl_A  = rst ? FWD_RF : fwd_a;
   assign forward_ctrl_B  = rst ? FWD_RF : fwd_b;
   assign forward_ctrl_ls = !rst && mem_ls_q;
   assign PC_EN_IF        = !stall;
   assign reg_FD_EN       = !stall;
   assign reg_DE_flush    = stall;
   assign reg_FD_flush    = !rst && branch_taken_ID && !stall;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage RV32I core. Sits beside the ID stage and consumes the decoder's per-instruction rs1use/rs2use/hazard_optype plus register addresses.
- Tracks in-flight producers in EX and MEM with its own shadow pipeline.
- Drives ID-stage operand forwarding selects, MEM-stage store-data forwarding, load-use stalls and taken-branch flushes.

Parameters:
- REG_AW, 5, register address width.
- OPT_W, 2, hazard_optype width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- rs1_addr_ID  input  REG_AW  rs1 of the instruction in ID.
- rs2_addr_ID  input  REG_AW  rs2 of the instruction in ID.
- rd_ID  input  REG_AW  rd of the instruction in ID.
- rs1use_ID  input  1  ID instruction reads rs1.
- rs2use_ID  input  1  ID instruction reads rs2.
- hazard_optype_ID  input  OPT_W  00 none, 01 ALU writer, 10 LOAD, 11 STORE. JAL and JALR must arrive as 01.
- branch_taken_ID  input  1  ID branch/jump resolved as taken (cmp result already applied).
- forward_ctrl_A  output  2  rs1 source in ID: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- forward_ctrl_B  output  2  rs2 source in ID, same encoding.
- forward_ctrl_ls  output  1  store in MEM takes its data from the WB load result.
- PC_EN_IF  output  1  PC update enable.
- reg_FD_EN  output  1  IF/ID register enable.
- reg_FD_flush  output  1  IF/ID register flush.
- reg_DE_flush  output  1  ID/EX register flush (bubble insert).

Behaviour:
- State is a shadow pipeline:
  - ex_opt/ex_rd and mem_opt/mem_rd track the producers in EX and MEM.
  - ex_ls/mem_ls are store-data-forward flags.
  - All state clears to 0 on rst.
- "Writer match" is true only when the source is used, the source address is non-zero, it equals the stage rd, and that stage's optype is 01 or 10. STORE and none never match.
- Forwarding (combinational from state and ID inputs):
  - Per source, EX has priority over MEM.
  - EX ALU match -> 01.
  - Else MEM ALU match -> 10.
  - Else MEM LOAD match -> 11.
  - Else 00.
- Load-use stall (stall = 1) in either case:
  - ex_opt==LOAD and ex_rd matches rs1 (any user).
  - ex_opt==LOAD and ex_rd matches rs2 while hazard_optype_ID != STORE.
- Store-data exception: ID is STORE, rs2 matches an EX LOAD, and rs1 does not match.
  - No stall.
  - forward_ctrl_B is don't-care (driven 00).
  - Sets ls_req = 1.
- Stall outputs: PC_EN_IF = ~stall, reg_FD_EN = ~stall, reg_DE_flush = stall.
- Flush: reg_FD_flush = branch_taken_ID & ~stall. Stall wins over a simultaneous branch; the branch re-resolves next cycle with valid operands.
- Clock edge, rst = 0:
  - mem_* <= ex_*; mem_ls <= ex_ls.
  - If stall: ex_opt <= 00, ex_rd <= 0, ex_ls <= 0.
  - Else: ex_opt <= hazard_optype_ID, ex_rd <= rd_ID, ex_ls <= ls_req.
- forward_ctrl_ls = mem_ls (store in MEM, load in WB). Latency from ID detection to assertion is exactly 2 cycles.
- Latency: all forwarding/stall/flush outputs are combinational, with zero-cycle response to ID inputs.
- Max stall length is 1 cycle. A bubble in EX cannot re-trigger a stall.
- Reset values, while rst is high: forwards 00, forward_ctrl_ls 0, PC_EN_IF 1, reg_FD_EN 1, both flushes 0, regardless of inputs. A reset mid-stall drops the stall in the same cycle, and all shadow state is cleared at the edge.
- x0 as producer rd or consumer rs never forwards and never stalls.

Decomposition:
- Shared package holds:
  - OPT_NONE/ALU/LOAD/STORE encodings, shared with the decoder's hazard_optype.
  - FWD_RF/EX_ALU/MEM_ALU/MEM_LOAD encodings.
- One sub-module, hazard_match: a combinational comparator (use, addr, stage_rd, stage_opt) -> alu_hit/load_hit, instantiated 4× (rs1/rs2 × EX/MEM).

Test Plan:
- add x5 in EX, then ID add x6,x5,x5 -> forward_ctrl_A=01, forward_ctrl_B=01, no stall. One cycle later with a bubble in EX -> A=10, B=10.
- lw x5 in EX, ID addi x7,x5,1 -> stall=1 for exactly one cycle (PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1). Next cycle -> forward_ctrl_A=11, stall=0.
- lw x5 in EX, ID sw x5,0(x8) -> no stall. forward_ctrl_ls=1 exactly 2 cycles later, 0 otherwise. Repeat with sw x9,0(x5) -> 1-cycle stall.
- beq taken in ID with no hazard -> reg_FD_flush=1. Same beq with rs1 = EX load rd -> cycle 1 stall=1, reg_FD_flush=0; cycle 2 reg_FD_flush=1.
- Producer rd=x0 (addi x0,…) followed by consumer of x0 -> forwards 00, no stall. EX and MEM both writing x3 -> forward selects 01 (EX priority).
- Assert rst during a load-use stall -> outputs immediately at reset values. After release, first ID consumer of the old load rd sees forwards 00.
